// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF2-to-ID instruction queue.
// Bubble values and pointer-width helper.
package if_id_queue_pkg;

  localparam logic [31:0] zero32 = 32'h0;
  localparam logic BUBBLE_FOUND = 1'b1;
  localparam logic BUBBLE_V = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Queue storage: one write port, one asynchronous read port.
// Contents are intentionally left unreset.
module if_id_queue_mem #(
  parameter int W = 66,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF2-to-ID instruction queue: lets fetch run ahead of a stalled decode.
// Flushed by exception clear or an unstalled branch; bubble when empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              pause,
  input  logic                    clear,
  input  logic                    branch,
  input  logic                    if_valid,
  output logic                    if_ready,
  output logic                    if_almost_full,
  input  logic [DATA_W-1:0]       if2_pc,
  input  logic [DATA_W-1:0]       if2_inst,
  input  logic                    if_inst_found,
  input  logic                    if_inst_v,
  output logic                    id_valid,
  output logic [DATA_W-1:0]       id_pc,
  output logic [DATA_W-1:0]       id_inst,
  output logic                    id_inst_found,
  output logic                    id_inst_v,
  output logic [clog2(DEPTH):0]   id_count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * DATA_W + 2;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(AFULL_TH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_we;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;
  logic [DATA_W-1:0] w_pc;
  logic [DATA_W-1:0] w_inst;
  logic          w_found;
  logic          w_v;
  logic          w_unused;

  assign w_unused = ^{pause[5:2], pause[0]};

  assign if_ready       = (r_count != FULL);
  assign if_almost_full = (r_count >= AFULL);
  assign id_valid       = (r_count != '0);
  assign id_count       = r_count;

  assign w_push  = if_valid && if_ready;
  assign w_pop   = id_valid && !pause[1];
  assign w_flush = clear || (branch && !pause[1]);
  assign w_we    = w_push && !w_flush;
  assign w_wdata = {if2_pc, if2_inst, if_inst_found, if_inst_v};

  // Full vs empty is decided by count; pointers alone are ambiguous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  if_id_queue_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign {w_pc, w_inst, w_found, w_v} = w_rdata;

  assign id_pc         = id_valid ? w_pc    : DATA_W'(zero32);
  assign id_inst       = id_valid ? w_inst  : DATA_W'(zero32);
  assign id_inst_found = id_valid ? w_found : BUBBLE_FOUND;
  assign id_inst_v     = id_valid ? w_v     : BUBBLE_V;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue.
// Scoreboard queue mirrors accepted entries; ID head compared to it.
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        f;
    logic        v;
  } ent_t;

  localparam logic [66:0] BUB = {1'b0, 32'h0, 32'h0, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pause;
  logic        clear;
  logic        branch;
  logic        if_valid;
  logic        if_ready;
  logic        if_almost_full;
  logic [31:0] if2_pc;
  logic [31:0] if2_inst;
  logic        if_inst_found;
  logic        if_inst_v;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_inst_found;
  logic        id_inst_v;
  logic [2:0]  id_count;

  ent_t        sb[$];
  logic [66:0] exp_head;
  logic [66:0] got_head;
  int          checks;
  int          failures;

  if_id_queue #(
    .DATA_W   (32),
    .DEPTH    (4),
    .AFULL_TH (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pause          (pause),
    .clear          (clear),
    .branch         (branch),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_almost_full (if_almost_full),
    .if2_pc         (if2_pc),
    .if2_inst       (if2_inst),
    .if_inst_found  (if_inst_found),
    .if_inst_v      (if_inst_v),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_inst_found  (id_inst_found),
    .id_inst_v      (id_inst_v),
    .id_count       (id_count)
  );

  always #5 clk = ~clk;

  assign got_head = {id_valid, id_pc, id_inst, id_inst_found, id_inst_v};

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic f,
                       input logic iv);
    if_valid      = v;
    if2_pc        = pc;
    if2_inst      = inst;
    if_inst_found = f;
    if_inst_v     = iv;
  endtask

  // Advance the reference model, then clock the DUT.
  task automatic tick();
    bit   p1;
    bit   fl;
    bit   pu;
    bit   po;
    ent_t e;
    p1 = pause[1];
    fl = clear || (branch && !p1);
    pu = if_valid && (sb.size() < 4);
    po = (sb.size() != 0) && !p1;
    e  = '{if2_pc, if2_inst, if_inst_found, if_inst_v};
    if (fl) begin
      sb.delete();
    end else begin
      if (po) void'(sb.pop_front());
      if (pu) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    pause = 6'b000010;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + 32'(4 * i), 32'hB000_0000 + base + 32'(i),
            1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pause = '0;
    clear = 1'b0;
    branch = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_head !== BUB) begin
      failures++;
      $display("FAIL reset_bubble got=%h exp=%h", got_head, BUB);
    end
    checks++;
    if ({if_ready, if_almost_full, id_count} !== {1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_flags got=%b/%b/%0d exp=1/0/0",
               if_ready, if_almost_full, id_count);
    end
    rst = 1'b1;
  endtask

  task automatic test_first_push();
    pause = '0;
    drive(1'b1, 32'h100, 32'h2402_0001, 1'b1, 1'b1);
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL first_pre_edge got=%h/%0d exp bubble/0",
               got_head, id_count);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({id_valid, id_pc, id_count} !== {1'b1, 32'h100, 3'd1}) begin
      failures++;
      $display("FAIL first_visible got=%b/%h/%0d exp=1/100/1",
               id_valid, id_pc, id_count);
    end
    exp_head = (sb.size() != 0) ? {1'b1, sb[0]} : BUB;
    checks++;
    if (got_head !== exp_head) begin
      failures++;
      $display("FAIL first_head got=%h exp=%h", got_head, exp_head);
    end
    tick();
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL first_drained got=%h/%0d exp bubble/0",
               got_head, id_count);
    end
  endtask

  task automatic test_fill_drain();
    pause = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({if_ready, if_almost_full} !==
          {sb.size() < 4, sb.size() >= 3}) begin
        failures++;
        $display("FAIL fill_flags[%0d] got=%b%b cnt=%0d", i,
                 if_ready, if_almost_full, sb.size());
      end
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h0A00_0000 + 32'(i),
            (i != 1), (i != 2));
      tick();
    end
    checks++;
    if ({id_count, if_ready, if_almost_full} !== {3'd4, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL fill_full got=%0d/%b/%b exp=4/0/1",
               id_count, if_ready, if_almost_full);
    end
    drive(1'b1, 32'h110, 32'h0A00_0004, 1'b1, 1'b1);
    tick();
    checks++;
    if ({id_count, id_pc} !== {3'd4, 32'h100}) begin
      failures++;
      $display("FAIL fill_drop5 got=%0d/%h exp=4/100", id_count, id_pc);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pause = '0;
    for (int i = 0; i < 4; i++) begin
      exp_head = (sb.size() != 0) ? {1'b1, sb[0]} : BUB;
      checks++;
      if (got_head !== exp_head || id_pc !== 32'h100 + 32'(4 * i)) begin
        failures++;
        $display("FAIL drain[%0d] got=%h exp=%h", i, got_head, exp_head);
      end
      tick();
    end
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL drain_end got=%h/%0d exp bubble/0", got_head, id_count);
    end
  endtask

  task automatic test_stream();
    pause = '0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i),
            i[0], ~i[1]);
      tick();
      exp_head = (sb.size() != 0) ? {1'b1, sb[0]} : BUB;
      checks++;
      if (id_count !== 3'd1 || id_pc !== 32'h300 + 32'(4 * i) ||
          got_head !== exp_head) begin
        failures++;
        $display("FAIL stream[%0d] got=%0d/%h exp=1/%h", i,
                 id_count, got_head, exp_head);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL stream_end got=%h/%0d exp bubble/0", got_head, id_count);
    end
  endtask

  task automatic test_branch();
    fill(3, 32'h140);
    pause = '0;
    branch = 1'b1;
    drive(1'b1, 32'h200, 32'hD000_0000, 1'b1, 1'b1);
    tick();
    branch = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL branch_flush got=%h/%0d exp bubble/0",
               got_head, id_count);
    end
    fill(3, 32'h120);
    branch = 1'b1;
    drive(1'b1, 32'h200, 32'hD000_0000, 1'b1, 1'b1);
    tick();
    branch = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({id_count, id_pc} !== {3'd4, 32'h120}) begin
      failures++;
      $display("FAIL branch_paused got=%0d/%h exp=4/120", id_count, id_pc);
    end
    pause = '0;
    for (int i = 0; i < 4; i++) begin
      exp_head = (sb.size() != 0) ? {1'b1, sb[0]} : BUB;
      checks++;
      if (got_head !== exp_head ||
          id_pc !== ((i < 3) ? 32'h120 + 32'(4 * i) : 32'h200)) begin
        failures++;
        $display("FAIL branch_drain[%0d] got=%h exp=%h", i,
                 got_head, exp_head);
      end
      tick();
    end
  endtask

  task automatic test_clear();
    fill(3, 32'h180);
    clear = 1'b1;
    drive(1'b1, 32'h240, 32'hE000_0000, 1'b1, 1'b1);
    tick();
    clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({got_head, id_count} !== {BUB, 3'd0}) begin
      failures++;
      $display("FAIL clear_flush got=%h/%0d exp bubble/0",
               got_head, id_count);
    end
    pause = '0;
  endtask

  task automatic test_async_reset();
    fill(2, 32'h1C0);
    checks++;
    if (id_count !== 3'd2) begin
      failures++;
      $display("FAIL areset_pre got=%0d exp=2", id_count);
    end
    #3;
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({got_head, id_count, if_ready} !== {BUB, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL areset_now got=%h/%0d/%b exp bubble/0/1",
               got_head, id_count, if_ready);
    end
    #1;
    rst = 1'b1;
    test_first_push();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_push();
    test_fill_drain();
    test_stream();
    test_branch();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
